interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_if.sv | 34 +++
 rtl/interrupt_controller.sv | 109 ++++++++++
 tb/tb_interrupt_controller.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_if.sv
// Core-side signal bundle for the interrupt controller.
// The slave modport is the controller; the master modport is the core or a test driver.
interface interrupt_controller_if;
  logic [8:0]  irq;
  logic        int_enable;
  logic        instr_boundary;
  logic [15:0] pc_current;
  logic        reti;
  logic        r_backup;
  logic        r_restore;
  logic [15:0] return_address_input;
  logic        return_address_write;
  logic [8:0]  interrupt_input;
  logic        interrupt_write;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic        stall;
  logic        in_service;
  logic [3:0]  active_index;

  modport slave (
    input  irq, int_enable, instr_boundary, pc_current, reti,
    output r_backup, r_restore, return_address_input, return_address_write,
           interrupt_input, interrupt_write, pc_load, pc_load_value,
           stall, in_service, active_index
  );

  modport master (
    output irq, int_enable, instr_boundary, pc_current, reti,
    input  r_backup, r_restore, return_address_input, return_address_write,
           interrupt_input, interrupt_write, pc_load, pc_load_value,
           stall, in_service, active_index
  );
endinterface

// File: rtl/interrupt_controller.sv
// Nine-line edge-triggered interrupt controller.
// It handles context save, vectoring, a single non-nested service, and restore.
//
// state   | meaning
// IDLE    | waiting for pending request with enable and instruction boundary
// SAVE    | back up accumulator, write return address, stall core
// VECTOR  | load PC with handler address, stall core
// SERVICE | handler running, waiting for reti
// RESTORE | restore accumulator, stall core, then back to IDLE
module interrupt_controller #(
  parameter logic [15:0] VECTOR_BASE = 16'h0100
) (
  input logic                    clk,
  input logic                    reset,
  interrupt_controller_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SAVE, VECTOR, SERVICE, RESTORE} state_t;

  state_t      state;
  logic [8:0]  irq_prev;
  logic [8:0]  pending;
  logic [8:0]  rise;
  logic [8:0]  clr;
  logic [8:0]  pending_next;
  logic [3:0]  active_index;
  logic [3:0]  lowest_idx;
  logic        take;

  assign bus.interrupt_input = pending;
  assign bus.active_index    = active_index;

  // A rise that lands on the same edge as the SAVE clear must win.
  always_comb begin
    rise         = bus.irq & ~irq_prev;
    clr          = '0;
    if (state == SAVE) clr = 9'b1 << active_index;
    pending_next = (pending & ~clr) | rise;
    lowest_idx   = '0;
    for (int i = 8; i >= 0; i--) begin
      if (pending[i]) lowest_idx = 4'(i);
    end
    take = (state == IDLE) && (pending != '0) && bus.int_enable && bus.instr_boundary;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                    <= IDLE;
      irq_prev                 <= '0;
      pending                  <= '0;
      active_index             <= '0;
      bus.interrupt_write      <= 1'b0;
      bus.r_backup             <= 1'b0;
      bus.r_restore            <= 1'b0;
      bus.return_address_write <= 1'b0;
      bus.return_address_input <= '0;
      bus.pc_load              <= 1'b0;
      bus.pc_load_value        <= '0;
      bus.stall                <= 1'b0;
      bus.in_service           <= 1'b0;
    end else begin
      irq_prev                 <= bus.irq;
      pending                  <= pending_next;
      bus.interrupt_write      <= (pending_next != pending);
      bus.r_backup             <= 1'b0;
      bus.r_restore            <= 1'b0;
      bus.return_address_write <= 1'b0;
      bus.return_address_input <= '0;
      bus.pc_load              <= 1'b0;
      bus.pc_load_value        <= '0;
      bus.stall                <= 1'b0;
      bus.in_service           <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            state                    <= SAVE;
            active_index             <= lowest_idx;
            bus.r_backup             <= 1'b1;
            bus.return_address_write <= 1'b1;
            bus.return_address_input <= bus.pc_current;
            bus.stall                <= 1'b1;
          end
        end
        SAVE: begin
          state             <= VECTOR;
          bus.pc_load       <= 1'b1;
          bus.pc_load_value <= VECTOR_BASE + {10'b0, active_index, 2'b00};
          bus.stall         <= 1'b1;
        end
        VECTOR: begin
          state          <= SERVICE;
          bus.in_service <= 1'b1;
        end
        SERVICE: begin
          if (bus.reti) begin
            state         <= RESTORE;
            bus.r_restore <= 1'b1;
            bus.stall     <= 1'b1;
          end else begin
            bus.in_service <= 1'b1;
          end
        end
        RESTORE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with hand-computed expectations.
module tb_interrupt_controller;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   wr_count;
  int   save_seen;

  interrupt_controller_if bus ();

  interrupt_controller #(.VECTOR_BASE(16'h0100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset              = 1'b1;
    bus.irq            = '0;
    bus.int_enable     = 1'b0;
    bus.instr_boundary = 1'b0;
    bus.pc_current     = '0;
    bus.reti           = 1'b0;
    step(); step();
    check("rst_stall", 32'(bus.stall), 0);
    check("rst_in_service", 32'(bus.in_service), 0);
    check("rst_int_input", 32'(bus.interrupt_input), 0);
    check("rst_int_write", 32'(bus.interrupt_write), 0);
    check("rst_pc_load_value", 32'(bus.pc_load_value), 0);
    check("rst_ra_input", 32'(bus.return_address_input), 0);
    check("rst_active_index", 32'(bus.active_index), 0);
    reset = 1'b0;
    step();
    check("post_rst_stall", 32'(bus.stall), 0);

    // Single request on line 3
    bus.int_enable     = 1'b1;
    bus.instr_boundary = 1'b1;
    bus.pc_current     = 16'h0042;
    bus.irq            = 9'h008;
    step();
    check("t1_pending", 32'(bus.interrupt_input), 32'h008);
    check("t1_int_write", 32'(bus.interrupt_write), 1);
    check("t1_no_stall_yet", 32'(bus.stall), 0);
    bus.irq = '0;
    step();
    check("t1_r_backup", 32'(bus.r_backup), 1);
    check("t1_ra_write", 32'(bus.return_address_write), 1);
    check("t1_ra_input", 32'(bus.return_address_input), 32'h0042);
    check("t1_save_stall", 32'(bus.stall), 1);
    check("t1_active_index", 32'(bus.active_index), 3);
    check("t1_save_no_pc_load", 32'(bus.pc_load), 0);
    step();
    check("t1_pc_load", 32'(bus.pc_load), 1);
    check("t1_pc_load_value", 32'(bus.pc_load_value), 32'h010C);
    check("t1_backup_off", 32'(bus.r_backup), 0);
    check("t1_pending_clr", 32'(bus.interrupt_input), 0);
    step();
    check("t1_in_service", 32'(bus.in_service), 1);
    check("t1_service_stall", 32'(bus.stall), 0);
    bus.reti = 1'b1;
    step();
    bus.reti = 1'b0;
    check("t1_r_restore", 32'(bus.r_restore), 1);
    check("t1_restore_stall", 32'(bus.stall), 1);
    check("t1_restore_not_in_service", 32'(bus.in_service), 0);
    step();
    check("t1_idle_restore_off", 32'(bus.r_restore), 0);
    check("t1_idle_stall", 32'(bus.stall), 0);

    // Simultaneous requests on lines 5 and 1
    bus.irq = 9'h022;
    step();
    check("t2_pending", 32'(bus.interrupt_input), 32'h022);
    bus.irq = '0;
    step();
    check("t2_first_index", 32'(bus.active_index), 1);
    step();
    check("t2_first_vector", 32'(bus.pc_load_value), 32'h0104);
    check("t2_pending_after_first", 32'(bus.interrupt_input), 32'h020);
    step();
    bus.reti = 1'b1;
    step();
    bus.reti = 1'b0;
    check("t2_restore", 32'(bus.r_restore), 1);
    step();
    check("t2_no_take_from_restore", 32'(bus.r_backup), 0);
    step();
    check("t2_second_save", 32'(bus.r_backup), 1);
    check("t2_second_index", 32'(bus.active_index), 5);
    step();
    check("t2_second_vector", 32'(bus.pc_load_value), 32'h0114);
    check("t2_pending_empty", 32'(bus.interrupt_input), 0);
    step();
    bus.reti = 1'b1;
    step();
    bus.reti = 1'b0;
    step();

    // Request deferred by int_enable low
    bus.int_enable = 1'b0;
    bus.irq        = 9'h001;
    step();
    check("t3_pending", 32'(bus.interrupt_input), 32'h001);
    check("t3_int_write", 32'(bus.interrupt_write), 1);
    bus.irq   = '0;
    wr_count  = 0;
    save_seen = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      if (bus.interrupt_write) wr_count++;
      if (bus.r_backup) save_seen++;
    end
    check("t3_single_write_pulse", 32'(wr_count), 0);
    check("t3_no_save", 32'(save_seen), 0);
    check("t3_pending_held", 32'(bus.interrupt_input), 32'h001);
    bus.int_enable = 1'b1;
    step();
    check("t3_save_on_enable", 32'(bus.r_backup), 1);
    check("t3_index", 32'(bus.active_index), 0);
    step();
    check("t3_vector", 32'(bus.pc_load_value), 32'h0100);
    step();

    // New request during service is held until after restore
    bus.irq = 9'h004;
    step();
    check("t4_pending_in_service", 32'(bus.interrupt_input), 32'h004);
    check("t4_no_nesting", 32'(bus.r_backup), 0);
    bus.irq = '0;
    step();
    check("t4_still_in_service", 32'(bus.in_service), 1);
    bus.reti = 1'b1;
    step();
    bus.reti = 1'b0;
    check("t4_restore", 32'(bus.r_restore), 1);
    step();
    check("t4_idle_gap", 32'(bus.r_backup), 0);
    step();
    check("t4_save", 32'(bus.r_backup), 1);
    check("t4_index", 32'(bus.active_index), 2);
    step();
    check("t4_vector", 32'(bus.pc_load_value), 32'h0108);
    step();
    bus.reti = 1'b1;
    step();
    bus.reti = 1'b0;
    step();

    // reti in IDLE is ignored
    bus.reti = 1'b1;
    step();
    bus.reti = 1'b0;
    check("t5_idle_reti_restore", 32'(bus.r_restore), 0);
    check("t5_idle_reti_stall", 32'(bus.stall), 0);
    check("t5_idle_reti_service", 32'(bus.in_service), 0);
    step();

    // Reset during service, then held irq pends after release
    bus.irq = 9'h010;
    step();
    bus.irq = '0;
    step(); step(); step();
    check("t6_in_service", 32'(bus.in_service), 1);
    bus.irq = 9'h040;
    step();
    check("t6_pending_before_reset", 32'(bus.interrupt_input), 32'h040);
    reset = 1'b1;
    step();
    check("t6_reset_service", 32'(bus.in_service), 0);
    check("t6_reset_pending", 32'(bus.interrupt_input), 0);
    check("t6_reset_restore", 32'(bus.r_restore), 0);
    check("t6_reset_stall", 32'(bus.stall), 0);
    reset = 1'b0;
    step();
    check("t6_held_irq_pends", 32'(bus.interrupt_input), 32'h040);
    check("t6_no_restore", 32'(bus.r_restore), 0);
    bus.irq = '0;
    step();
    check("t7_save", 32'(bus.r_backup), 1);
    check("t7_index", 32'(bus.active_index), 6);
    bus.irq = 9'h040;
    step();
    check("t7_set_wins_over_clear", 32'(bus.interrupt_input), 32'h040);
    check("t7_vector", 32'(bus.pc_load_value), 32'h0118);
    bus.irq = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
